// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, instruction field positions, halt opcode
// and fetch state codes. Imported by the fetch stage and its IF/ID register.
package cpu_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_INSN_W = 16;
    localparam int OP_W       = 4;
    localparam int REG_W      = 4;

    localparam logic [OP_W-1:0] HALT_OP = 4'hF;

    // Field MSB positions inside a 16-bit instruction word.
    localparam int OP_MSB = 15;
    localparam int RS_MSB = 11;
    localparam int RT_MSB = 7;
    localparam int RD_MSB = 3;

    // Fetch state codes, kept as plain constants so older tools can read them.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Symbolic names for the same codes, handy for checkers and waveforms.
    typedef enum logic [1:0] {
        BOOT = ST_BOOT,
        RUN  = ST_RUN,
        HALT = ST_HALT
    } fetch_state_e;

    function automatic logic [OP_W-1:0] op_of(input logic [DEF_INSN_W-1:0] insn);
        return insn[OP_MSB -: OP_W];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings: instruction memory
// request/response, pipeline control, and the IF/ID register outputs.
//
// Signalling: there is no ready/back-pressure path on this bundle. The memory
// side is a combinational read (instruction answers IAddress in the same
// cycle). Downstream must treat id_* as meaningful only while id_valid is 1;
// stall holds the IF/ID contents unchanged, redirect_en clears id_valid.
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSN_W = DEF_INSN_W
);
    logic              stall;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_addr;
    logic [INSN_W-1:0] instruction;

    logic [ADDR_W-1:0] IAddress;
    logic              InsMemRW;

    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INSN_W-1:0] id_instruction;
    logic [OP_W-1:0]   id_op;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              halted;
    logic [1:0]        dbg_state;

    modport master (
        input  stall, redirect_en, redirect_addr, instruction,
        output IAddress, InsMemRW, id_valid, id_pc, id_instruction,
               id_op, id_rs, id_rt, id_rd, halted, dbg_state
    );

    modport slave (
        output stall, redirect_en, redirect_addr, instruction,
        input  IAddress, InsMemRW, id_valid, id_pc, id_instruction,
               id_op, id_rs, id_rt, id_rd, halted, dbg_state
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid flag, fetch address and instruction word,
// with load / flush / hold control, plus the decoder field split.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSN_W = DEF_INSN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [INSN_W-1:0] d_instruction,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [INSN_W-1:0] instruction,
    output logic [OP_W-1:0]   op,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [REG_W-1:0]  rd
);

    // Reset clears everything; flush only drops valid so the stale word stays
    // visible for debug; load captures a new fetch; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= 1'b0;
            pc          <= '0;
            instruction <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid       <= 1'b1;
            pc          <= d_pc;
            instruction <= d_instruction;
        end
    end

    assign op = instruction[OP_MSB -: OP_W];
    assign rs = instruction[RS_MSB -: REG_W];
    assign rt = instruction[RT_MSB -: REG_W];
    assign rd = instruction[RD_MSB -: REG_W];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, BOOT/RUN/HALT control and the
// IF/ID register feeding the decoder.
// Optional build macro FETCH_COUNT_EN adds a 32-bit fetch_count output that
// counts instructions loaded into IF/ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              INSN_W   = DEF_INSN_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OP_W-1:0]   HALT_OP  = cpu_pkg::HALT_OP
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.master bus
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]  fetch_count
`endif
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              load;
    logic              flush;

    // Next PC / state and IF/ID control; redirect beats stall beats fetch.
    always_comb begin
        next_pc    = pc;
        next_state = state;
        load       = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_BOOT: begin
                flush      = 1'b1;
                next_state = ST_RUN;
                if (bus.redirect_en) next_pc = bus.redirect_addr;
            end
            ST_RUN: begin
                if (bus.redirect_en) begin
                    next_pc = bus.redirect_addr;
                    flush   = 1'b1;
                end else if (!bus.stall) begin
                    load = 1'b1;
                    if (op_of(bus.instruction) == HALT_OP) next_state = ST_HALT;
                    else                                   next_pc    = pc + 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.redirect_en) begin
                    next_pc    = bus.redirect_addr;
                    flush      = 1'b1;
                    next_state = ST_RUN;
                end else if (!bus.stall) begin
                    // The halt word has been presented once; retire it.
                    flush = 1'b1;
                end
            end
            default: next_state = ST_BOOT;
        endcase
    end

    // PC and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= ST_BOOT;
        end else begin
            pc    <= next_pc;
            state <= next_state;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W)
    ) u_if_id (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .flush         (flush),
        .d_pc          (pc),
        .d_instruction (bus.instruction),
        .valid         (bus.id_valid),
        .pc            (bus.id_pc),
        .instruction   (bus.id_instruction),
        .op            (bus.id_op),
        .rs            (bus.id_rs),
        .rt            (bus.id_rt),
        .rd            (bus.id_rd)
    );

    assign bus.IAddress  = pc;
    assign bus.InsMemRW  = 1'b0;
    assign bus.halted    = (state == ST_HALT);
    assign bus.dbg_state = state;

`ifdef FETCH_COUNT_EN
    // Count every edge on which IF/ID captures a fetched instruction.
    always_ff @(posedge clk) begin
        if (rst)       fetch_count <= '0;
        else if (load) fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall /
// redirect / reset traffic, checked against a behavioural model.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory image, read combinationally.
    logic [15:0] mem [0:65535];
    assign bus.instruction = mem[bus.IAddress];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_id_pc;
    logic [15:0] m_id_insn;
    bit          m_boot;
    bit          m_halt;
    bit          m_valid;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rand_insn();
        logic [3:0] op;
        op = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        return {op, 12'($urandom)};
    endfunction

    // Model: one clock edge of the fetch stage, described by its rules.
    task automatic model_edge(input bit r, input bit s, input bit re, input logic [15:0] ra);
        logic [15:0] w;
        if (r) begin
            m_pc = 16'h0000; m_boot = 1; m_halt = 0; m_valid = 0;
            m_id_pc = 16'h0000; m_id_insn = 16'h0000; m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 0;
            m_valid = 0;
            if (re) m_pc = ra;
        end else if (re) begin
            m_pc = ra; m_valid = 0; m_halt = 0;
        end else if (m_halt) begin
            if (!s) m_valid = 0;
        end else if (!s) begin
            w = mem[m_pc];
            m_id_pc = m_pc; m_id_insn = w; m_valid = 1; m_cnt = m_cnt + 1;
            if (w[15:12] == 4'hF) m_halt = 1;
            else                  m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic compare_all();
        fetch_state_e exp_state;
        exp_state = m_boot ? BOOT : (m_halt ? HALT : RUN);
        check("iaddress", bus.IAddress, m_pc);
        check("insmemrw", bus.InsMemRW, 0);
        check("id_valid", bus.id_valid, m_valid);
        check("id_pc", bus.id_pc, m_id_pc);
        check("id_instruction", bus.id_instruction, m_id_insn);
        check("id_op", bus.id_op, m_id_insn / 4096);
        check("id_rs", bus.id_rs, (m_id_insn / 256) % 16);
        check("id_rt", bus.id_rt, (m_id_insn / 16) % 16);
        check("id_rd", bus.id_rd, m_id_insn % 16);
        check("halted", bus.halted, m_halt);
        check("state", bus.dbg_state, exp_state);
`ifdef FETCH_COUNT_EN
        check("fetch_count", fetch_count, m_cnt);
`endif
    endtask

    // Driver: apply inputs, advance one edge, update model, compare.
    task automatic step(input bit r, input bit s, input bit re, input logic [15:0] ra);
        rst = r;
        bus.stall = s;
        bus.redirect_en = re;
        bus.redirect_addr = ra;
        @(posedge clk);
        model_edge(r, s, re, ra);
        #1;
        compare_all();
    endtask

    task automatic run_until_pc(input logic [15:0] target);
        int guard;
        guard = 0;
        while (m_pc != target && guard < 64) begin
            step(0, 0, 0, 16'h0);
            guard++;
        end
        check("reach_pc", bus.IAddress, target);
    endtask

    initial begin
        bus.stall = 0;
        bus.redirect_en = 0;
        bus.redirect_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = rand_insn();
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
        // Keep directed paths free of halt words.
        for (int i = 3; i < 16'h0050; i++)
            if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h1;
        if (mem[16'hFFFF][15:12] == 4'hF) mem[16'hFFFF][15:12] = 4'h2;

        // Reset then run.
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        check("reset_state", bus.dbg_state, BOOT);
        step(0, 0, 0, 16'h0);               // BOOT
        check("boot_iaddr", bus.IAddress, 16'h0000);
        step(0, 0, 0, 16'h0);               // first fetch
        check("first_insn", bus.id_instruction, 16'h1234);
        check("first_fields", {bus.id_op, bus.id_rs, bus.id_rt, bus.id_rd}, 16'h1234);
        check("first_valid", bus.id_valid, 1);
        check("first_iaddr", bus.IAddress, 16'h0001);

        // Stall at pc=5.
        run_until_pc(16'h0005);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0);
        check("stall_iaddr", bus.IAddress, 16'h0005);
        step(0, 0, 0, 16'h0);
        check("resume_pc5", bus.id_pc, 16'h0005);
        step(0, 0, 0, 16'h0);
        check("resume_pc6", bus.id_pc, 16'h0006);

        // Redirect together with stall at pc=8.
        run_until_pc(16'h0008);
        step(0, 1, 1, 16'h0040);
        check("redir_iaddr", bus.IAddress, 16'h0040);
        check("redir_flush", bus.id_valid, 0);
        step(0, 0, 0, 16'h0);
        check("redir_id_pc", bus.id_pc, 16'h0040);

        // Wrap-around.
        step(0, 0, 1, 16'hFFFF);
        step(0, 0, 0, 16'h0);
        check("wrap_iaddr", bus.IAddress, 16'h0000);

        // Mid-run reset.
        step(0, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        check("midrst_iaddr", bus.IAddress, 16'h0000);
        check("midrst_valid", bus.id_valid, 0);

        // Halt at pc=3.
        mem[3] = 16'hF000;
        step(0, 0, 0, 16'h0);               // BOOT
        run_until_pc(16'h0003);
        step(0, 0, 0, 16'h0);               // fetch halt word
        check("halt_op", bus.id_op, 4'hF);
        check("halt_issue", bus.id_valid, 1);
        step(0, 1, 0, 16'h0);               // stall while halted
        step(0, 0, 0, 16'h0);
        check("halt_retired", bus.id_valid, 0);
        check("halt_flag", bus.halted, 1);
        step(0, 0, 0, 16'h0);
        check("halt_iaddr", bus.IAddress, 16'h0003);
        step(0, 0, 1, 16'h0010);
        check("unhalt", bus.halted, 0);
        step(0, 0, 0, 16'h0);
        check("unhalt_id_pc", bus.id_pc, 16'h0010);

        // Redirect on the cycle a halt word is fetched.
        step(0, 0, 1, 16'h0003);
        step(0, 0, 1, 16'h0020);
        check("redir_over_halt", bus.halted, 0);
        step(0, 0, 0, 16'h0);
        check("redir_over_halt_pc", bus.id_pc, 16'h0020);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, s, re;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 7) == 0);
            step(r, s, re, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of InstructionMemory. It owns the program counter, drives IAddress and InsMemRW to the memory, and captures the returned 16-bit instruction into an IF/ID pipeline register with op/rs/rt/rd fields split out for the decoder. It handles stall, redirect (branch/jump) and a halt opcode through a small state machine.

Parameters:
ADDR_W, 16, PC / IAddress width (word-addressed; PC steps by 1)
INSN_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OP, 4'hF, opcode that stops fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC and IF/ID contents this cycle
redirect_en  in  1  load PC from redirect_addr and flush IF/ID
redirect_addr  in  ADDR_W  redirect target
instruction  in  INSN_W  combinational read data from InstructionMemory
IAddress  out  ADDR_W  = pc register (combinational from register)
InsMemRW  out  1  constant 0 (read)
id_valid  out  1  IF/ID holds a real instruction
id_pc  out  ADDR_W  address of the instruction in IF/ID
id_instruction  out  INSN_W  latched instruction
id_op / id_rs / id_rt / id_rd  out  4 each  fields [15:12] / [11:8] / [7:4] / [3:0] of id_instruction
halted  out  1  high while in HALT state

Behaviour:
- Single clock clk; rst is synchronous, active-high. Every register resets on the clk edge where rst=1, including mid-operation; rst overrides all other inputs.
- Reset values: pc=RESET_PC, state=BOOT, id_valid=0, id_pc=0, id_instruction=0 (fields 0), halted=0.
- Memory read is combinational: instruction corresponding to IAddress is sampled on the same edge. Fetch-to-IF/ID latency is 1 cycle.
- States:
  - BOOT: one cycle; id_valid=0, pc held; next state RUN. redirect_en in BOOT loads pc and still goes to RUN.
  - RUN, priority redirect > stall > fetch:
    - redirect_en=1: pc<=redirect_addr, id_valid<=0, stay RUN.
    - stall=1: pc and all IF/ID registers hold.
    - Otherwise: id_pc<=pc, id_instruction<=instruction, id_valid<=1.
      - If instruction[15:12]==HALT_OP: pc holds and next state is HALT.
      - Else pc<=pc+1.
  - HALT: halted=1, pc holds, IAddress stays at the halt address.
    - stall=1: IF/ID holds.
    - stall=0: id_valid<=0 (the halt instruction issues exactly once).
    - redirect_en=1: pc<=redirect_addr, id_valid<=0, next state RUN, halted<=0 on the same edge.
- Wrap-around: pc 16'hFFFF increments to 16'h0000 (modulo 2^ADDR_W), no flag.
- Simultaneous redirect_en and stall: redirect wins; the flush happens even though the stall is high.
- Redirect on the same cycle a HALT_OP is fetched: the redirect wins; halt is not entered and the instruction is discarded.
- InsMemRW is 0 in every state, including reset.

Optional Feature:
FETCH_COUNT_EN:
- Defined: adds output port fetch_count (32 bits), reset to 0 and incremented by 1 on each edge where IF/ID loads a valid instruction (RUN fetch path). It does not count stalls, flushes or idle cycles in HALT/BOOT, and wraps at 2^32.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - OP_W=4, REG_W=4, ADDR_W/INSN_W defaults
  - HALT_OP constant
  - field bit positions (OP_MSB=15, RS_MSB=11, RT_MSB=7, RD_MSB=3)
  - fetch state enum {BOOT, RUN, HALT}
- One natural sub-module, if_id_reg: holds id_valid/id_pc/id_instruction with load, hold and flush controls, and does the field split. The PC and FSM stay in fetch_stage.

Test Plan:
- Reset then run: rst=1 for 2 cycles, memory returns 16'h1234,16'h2345,16'h3456 at addresses 0,1,2 -> IAddress 0,0(BOOT),1,2,3; id_instruction 16'h1234 with id_op=1,id_rs=2,id_rt=3,id_rd=4, id_pc=0, id_valid=1 one cycle after RUN.
- Stall: assert stall for 3 cycles at pc=5 -> IAddress stays 5, id_* unchanged for 3 cycles; fetch resumes at 5 then 6.
- Redirect with stall: pc=8, stall=1 and redirect_en=1 with redirect_addr=16'h0040 -> next cycle IAddress=16'h0040, id_valid=0; following cycle id_pc=16'h0040.
- Halt: instruction 16'hF000 at pc=3 -> id_op=4'hF with id_valid=1 for one cycle, then id_valid=0, halted=1, IAddress stays 3. redirect_en with redirect_addr=16'h0010 -> halted=0, fetch resumes at 16'h0010.
- Wrap and mid-run reset: redirect to 16'hFFFF -> the next IAddress after fetch is 16'h0000. Assert rst mid-run -> pc=RESET_PC, id_valid=0, state BOOT on that edge. With FETCH_COUNT_EN, fetch_count=0 after reset and equals the number of id_valid loads.
